// File: rtl/adsr_envelope.sv
// ADSR envelope generator: turns a gate into a 10-bit amplitude with linear,
// saturating per-tick slopes. All outputs come straight from flops.
module adsr_envelope #(
    parameter int CLKSPEED = 50_000_000,
    parameter int TICK_HZ  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic [9:0] attack_step,
    input  logic [9:0] decay_step,
    input  logic [9:0] sustain_level,
    input  logic [9:0] release_step,
    output logic [9:0] amp_out,
    output logic [2:0] stage,
    output logic       busy
);
    localparam int DIV = CLKSPEED / TICK_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [9:0]  amp_nx;
    logic [CW-1:0] cnt;
    logic        tick;
    logic        gate_m, gate_s, gate_d;
    logic        rise, held;
    logic [10:0] sum, dthr;

    // gate_m/gate_s form the synchronizer; gate_d only exists for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_m <= 1'b0;
            gate_s <= 1'b0;
            gate_d <= 1'b0;
            cnt    <= '0;
        end else begin
            gate_m <= gate;
            gate_s <= gate_m;
            gate_d <= gate_s;
            cnt    <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(DIV - 1));
    assign rise = gate_s & ~gate_d;
    assign held = (state == ATTACK) || (state == DECAY) || (state == SUSTAIN);
    assign sum  = {1'b0, amp_out} + {1'b0, attack_step};
    assign dthr = {1'b0, sustain_level} + {1'b0, decay_step};

    // Gate events win over the tick and freeze amp_out for that cycle.
    always_comb begin
        state_nx = state;
        amp_nx   = amp_out;
        if (rise) begin
            state_nx = ATTACK;
        end else if (!gate_s && held) begin
            state_nx = RELEASE;
        end else if (tick) begin
            case (state)
                ATTACK: begin
                    if (sum >= 11'd1023) begin
                        amp_nx   = 10'd1023;
                        state_nx = DECAY;
                    end else begin
                        amp_nx = sum[9:0];
                    end
                end
                DECAY: begin
                    if ({1'b0, amp_out} <= dthr) begin
                        amp_nx   = sustain_level;
                        state_nx = SUSTAIN;
                    end else begin
                        amp_nx = amp_out - decay_step;
                    end
                end
                SUSTAIN: amp_nx = sustain_level;
                RELEASE: begin
                    if (amp_out <= release_step) begin
                        amp_nx   = 10'd0;
                        state_nx = IDLE;
                    end else begin
                        amp_nx = amp_out - release_step;
                    end
                end
                default: amp_nx = 10'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            amp_out <= 10'd0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            amp_out <= amp_nx;
            busy    <= (state_nx != IDLE);
        end
    end

    assign stage = state;
endmodule

// File: tb/tb_adsr_envelope.sv
// Randomized bench for adsr_envelope: a cycle reference model feeds a scoreboard
// queue that a negedge monitor drains against the DUT outputs.
module tb_adsr_envelope;
    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst, gate;
    logic [9:0] attack_step, decay_step, sustain_level, release_step;
    logic [9:0] amp_out;
    logic [2:0] stage;
    logic       busy;

    adsr_envelope #(.CLKSPEED(1000), .TICK_HZ(100)) dut (
        .clk(clk), .rst(rst), .gate(gate),
        .attack_step(attack_step), .decay_step(decay_step),
        .sustain_level(sustain_level), .release_step(release_step),
        .amp_out(amp_out), .stage(stage), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int amp; int st; bit bsy; } exp_t;
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   shown  = 0;

    // Reference model: gate seen two edges late, edge against three edges late;
    // tick on every DIV-th edge counted from reset.
    int m_amp = 0, m_st = 0, m_n = 0;
    bit hist[$] = '{0, 0, 0};

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_amp = 0; m_st = 0; m_n = 0;
            hist = '{0, 0, 0};
        end else begin
            bit gs, gd, tk;
            gs = hist[1];
            gd = hist[2];
            hist.push_front(gate);
            void'(hist.pop_back());
            m_n++;
            tk = (m_n % DIV) == 0;
            if (gs && !gd) begin
                m_st = 1;
            end else if (!gs && m_st >= 1 && m_st <= 3) begin
                m_st = 4;
            end else if (tk) begin
                if (m_st == 1) begin
                    m_amp = m_amp + int'(attack_step);
                    if (m_amp >= 1023) begin m_amp = 1023; m_st = 2; end
                end else if (m_st == 2) begin
                    if (m_amp <= int'(sustain_level) + int'(decay_step)) begin
                        m_amp = int'(sustain_level); m_st = 3;
                    end else m_amp = m_amp - int'(decay_step);
                end else if (m_st == 3) begin
                    m_amp = int'(sustain_level);
                end else if (m_st == 4) begin
                    if (m_amp <= int'(release_step)) begin m_amp = 0; m_st = 0; end
                    else m_amp = m_amp - int'(release_step);
                end
            end
        end
        sbq.push_back('{m_amp, m_st, m_st != 0});
    end

    bit cap = 0;
    int capv[$];
    int last_amp = 0;

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (int'(amp_out) != e.amp || int'(stage) != e.st || busy != e.bsy) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL scoreboard t=%0t amp=%0d exp %0d stage=%0d exp %0d busy=%0d exp %0d",
                             $time, amp_out, e.amp, stage, e.st, busy, e.bsy);
                end
            end
        end
        if (cap && int'(amp_out) != last_amp) begin
            last_amp = int'(amp_out);
            capv.push_back(last_amp);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind 0: model amp == val, 1: model stage == val, 2: gate change now lands on a tick edge
    task automatic wait_until(input int kind, input int val);
        int k;
        bit ok;
        k = 0;
        ok = 0;
        while (k < 500 && !ok) begin
            ok = (kind == 0) ? (m_amp == val) :
                 (kind == 1) ? (m_st == val)  : (((m_n + 3) % DIV) == 0);
            if (!ok) begin @(negedge clk); k++; end
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL wait_timeout kind=%0d target=%0d got amp=%0d stage=%0d", kind, val, m_amp, m_st);
        end
    endtask

    function automatic logic [9:0] rnd_step();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 10'd0;
        if (r == 1) return 10'd1023;
        if (r < 5) return 10'($urandom_range(1, 40));
        return 10'($urandom_range(0, 1023));
    endfunction

    int exp_seq[10] = '{256, 512, 768, 1023, 923, 823, 723, 700, 350, 0};

    initial begin
        rst = 1'b1; gate = 1'b0;
        attack_step = 10'd256; decay_step = 10'd100;
        sustain_level = 10'd700; release_step = 10'd350;
        cyc(3);
        rst = 1'b0;
        cyc(50);

        // Full envelope: capture each distinct amp_out value the DUT shows
        last_amp = 0; cap = 1;
        gate = 1'b1;
        cyc(150);
        gate = 1'b0;
        cyc(40);
        cap = 0;
        checks++;
        if (capv.size() != 10) begin
            errors++;
            $display("FAIL seq_len got %0d exp 10", capv.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (capv[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL seq[%0d] got %0d exp %0d", i, capv[i], exp_seq[i]);
                end
            end
        end

        // Release from mid-attack, then legato retrigger from 162
        gate = 1'b1;
        wait_until(0, 512);
        gate = 1'b0;
        wait_until(0, 162);
        gate = 1'b1;
        cyc(40);
        gate = 1'b0;
        wait_until(1, 0);

        // Gate fall landing on a tick edge
        gate = 1'b1;
        wait_until(1, 3);
        wait_until(2, 0);
        gate = 1'b0;
        wait_until(1, 0);

        // Reset mid-decay with gate still held
        gate = 1'b1;
        wait_until(1, 2);
        rst = 1'b1; cyc(1); rst = 1'b0;
        cyc(30);

        // Live sustain tracking, then a stuck attack
        wait_until(1, 3);
        sustain_level = 10'd900;
        cyc(25);
        attack_step = 10'd0;
        gate = 1'b0;
        cyc(8);
        gate = 1'b1;
        cyc(80);
        gate = 1'b0;
        attack_step = 10'd256;
        wait_until(1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) gate = ~gate;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) attack_step   = rnd_step();
            if ($urandom_range(0, 99) == 0) decay_step    = rnd_step();
            if ($urandom_range(0, 99) == 0) sustain_level = rnd_step();
            if ($urandom_range(0, 99) == 0) release_step  = rnd_step();
            cyc(1);
        end
        rst = 1'b0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
